// File: rtl/multicycle_core_ctrl.sv
// multicycle_core_ctrl
//   Multi-cycle sequencer for the RISC core. Steps each instruction through
//   FETCH / DECODE / EXEC / [MEM] / [WBACK], owns the PC and instruction
//   register, and handshakes with instruction and data memory via req/ack.
//   It also provides run/pause at instruction boundaries, a sticky HALT,
//   a sticky memory-timeout FAULT and a saturating retired-instruction count.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   run                        1 = execute, 0 = stop at next instruction boundary
//   imem_req/addr/ack/rdata    instruction fetch handshake (addr = pc)
//   dec_is_ld/st/wb/halt       combinational decode of ir from Control
//   ex_branch_taken/pc         branch decision and target from EX
//   dmem_req/we/ack            data memory handshake (we = 1 for store)
//   pc, ir                     current instruction PC and instruction register
//   of_en, ex_en, rf_we        one-cycle stage enables
//   state                      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WBACK=5 HALT=6 FAULT=7
//   halted, fault              sticky status flags
//   retired                    retired-instruction count, saturating
module multicycle_core_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4,
  parameter int              TIMEOUT  = 16,
  parameter int              CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             run,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             dec_is_ld,
  input  logic             dec_is_st,
  input  logic             dec_is_wb,
  input  logic             dec_is_halt,
  input  logic             ex_branch_taken,
  input  logic [XLEN-1:0]  ex_branch_pc,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  ir,
  output logic             of_en,
  output logic             ex_en,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WBACK  = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, ir_q, ir_d, br_pc_q, br_pc_d;
  logic             br_taken_q, br_taken_d;
  logic [31:0]      wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic             of_en_q, of_en_d, ex_en_q, ex_en_d, rf_we_q, rf_we_d;
  logic             halted_q, halted_d, fault_q, fault_d;
  logic             retire, req_now, ack_now, take;
  logic [XLEN-1:0]  target;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    br_taken_d = br_taken_q;
    br_pc_d    = br_pc_q;
    retired_d  = retired_q;
    wait_d     = '0;
    retire     = 1'b0;

    // Retiring straight out of EXEC happens on the same edge that would
    // latch the branch, so use EX's live decision there.
    take   = (state_q == S_EXEC) ? ex_branch_taken : br_taken_q;
    target = (state_q == S_EXEC) ? ex_branch_pc    : br_pc_q;

    req_now = (state_q == S_FETCH) || (state_q == S_MEM);
    ack_now = ((state_q == S_FETCH) && imem_ack) || ((state_q == S_MEM) && dmem_ack);

    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = dec_is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        br_taken_d = ex_branch_taken;
        br_pc_d    = ex_branch_pc;
        if (dec_is_ld || dec_is_st) state_d = S_MEM;
        else if (dec_is_wb)         state_d = S_WBACK;
        else                        retire  = 1'b1;
      end
      S_MEM: begin
        // A store wins over a load when both decode bits are set.
        if (dmem_ack) begin
          if (dec_is_ld && !dec_is_st) state_d = S_WBACK;
          else                         retire  = 1'b1;
        end
      end
      S_WBACK:  retire = 1'b1;
      default:  state_d = state_q;  // HALT and FAULT hold until Reset
    endcase

    if (retire) begin
      pc_d = take ? target : pc_q + XLEN'(PC_INC);
      if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end

    // Wait counter only advances while stalled; an ack on the limit cycle
    // has already moved the FSM on, so it beats the fault.
    if ((TIMEOUT > 0) && req_now && !ack_now) begin
      if (wait_q == 32'(TIMEOUT - 1)) state_d = S_FAULT;
      else                            wait_d  = wait_q + 32'd1;
    end

    // Registered outputs are decoded from the state being entered.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && dec_is_st;
    of_en_d    = (state_d == S_DECODE);
    ex_en_d    = (state_d == S_EXEC);
    rf_we_d    = (state_d == S_WBACK);
    halted_d   = (state_d == S_HALT);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      wait_q     <= '0;
      retired_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      of_en_q    <= 1'b0;
      ex_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      of_en_q    <= of_en_d;
      ex_en_q    <= ex_en_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign of_en     = of_en_q;
  assign ex_en     = ex_en_q;
  assign rf_we     = rf_we_q;
  assign state     = state_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl. Instruction encoding used by the
// bench's stand-in for Control: bit0 = wb, bit1 = ld, bit2 = st, bit3 = halt.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multicycle_core_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, run;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dec_is_ld, dec_is_st, dec_is_wb, dec_is_halt;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_pc;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] pc, ir;
  logic        of_en, ex_en, rf_we;
  logic [2:0]  state;
  logic        halted, fault;
  logic [2:0]  retired;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  assign dec_is_wb   = ir[0];
  assign dec_is_ld   = ir[1];
  assign dec_is_st   = ir[2];
  assign dec_is_halt = ir[3];

  multicycle_core_ctrl #(
    .XLEN(32), .RESET_PC(32'h0), .PC_INC(4), .TIMEOUT(16), .CNT_W(3)
  ) dut (
    .Clk(Clk), .Reset(Reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_is_ld(dec_is_ld), .dec_is_st(dec_is_st), .dec_is_wb(dec_is_wb), .dec_is_halt(dec_is_halt),
    .ex_branch_taken(ex_branch_taken), .ex_branch_pc(ex_branch_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc(pc), .ir(ir), .of_en(of_en), .ex_en(ex_en), .rf_we(rf_we),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  // Outcome of one instruction driven by run_instr.
  int          r_cyc, r_rfwe, r_dreq, r_we, r_of, r_ex;
  logic [31:0] r_faddr;

  task automatic do_reset();
    Reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = '0; ex_branch_taken = 1'b0; ex_branch_pc = '0;
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Starts at a falling edge with the DUT in FETCH; acks each request after
  // the given number of wait cycles and returns at the falling edge where the
  // next instruction starts (or IDLE/HALT/FAULT is reached). Bounded.
  task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                           input bit drop_run);
    int  iw, dw;
    bit  done, left;
    r_cyc = 0; r_rfwe = 0; r_dreq = 0; r_we = 0; r_of = 0; r_ex = 0;
    r_faddr = imem_addr; iw = 0; dw = 0; done = 1'b0; left = 1'b0;
    while (!done && r_cyc < 64) begin
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = instr;
      if (rf_we) r_rfwe++;
      if (of_en) r_of++;
      if (ex_en) r_ex++;
      if (dmem_req) r_dreq++;
      if (dmem_req && dmem_we) r_we++;
      if (imem_req) begin if (iw >= iwait) imem_ack = 1'b1; iw++; end
      if (dmem_req) begin if (dw >= dwait) dmem_ack = 1'b1; dw++; end
      if (drop_run && state == 3'd3) run = 1'b0;
      r_cyc++;
      @(negedge Clk);
      if (state != 3'd1) left = 1'b1;
      if (state == 3'd0 || state == 3'd6 || state == 3'd7 || (state == 3'd1 && left)) done = 1'b1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if (ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%0h want=0", ir); end
    total++; if ({imem_req, dmem_req, dmem_we, of_en, ex_en, rf_we, halted, fault} !== 8'h0)
      begin bad++; $display("FAIL reset_outs got=%b want=0", {imem_req, dmem_req, dmem_we, of_en, ex_en, rf_we, halted, fault}); end
    total++; if (retired !== 3'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    @(negedge Clk);
    total++; if (state !== 3'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL idle_hold got=%0d want=0", state); end
  endtask

  task automatic test_alu();
    logic [31:0] exp_addr [3] = '{32'h0, 32'h4, 32'h8};
    run = 1'b1;
    @(negedge Clk);
    total++; if (state !== 3'd1 || imem_req !== 1'b1) begin bad++; $display("FAIL alu_fetch got=%0d want=1", state); end
    for (int i = 0; i < 3; i++) begin
      run_instr(32'h1, 0, 0, 1'b0);
      total++; if (r_cyc !== 4) begin bad++; $display("FAIL alu_cycles got=%0d want=4", r_cyc); end
      total++; if (r_faddr !== exp_addr[i]) begin bad++; $display("FAIL alu_addr got=%0h want=%0h", r_faddr, exp_addr[i]); end
      total++; if (r_rfwe !== 1 || r_of !== 1 || r_ex !== 1 || r_dreq !== 0)
        begin bad++; $display("FAIL alu_pulses got=%0d%0d%0d%0d want=1110", r_rfwe, r_of, r_ex, r_dreq); end
    end
    total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL alu_pc got=%0h want=c", imem_addr); end
    total++; if (retired !== 3'd3) begin bad++; $display("FAIL alu_retired got=%0d want=3", retired); end
  endtask

  task automatic test_load_wait();
    run_instr(32'h3, 0, 2, 1'b0);
    total++; if (r_cyc !== 7) begin bad++; $display("FAIL ld_cycles got=%0d want=7", r_cyc); end
    total++; if (r_dreq !== 3 || r_we !== 0) begin bad++; $display("FAIL ld_mem got=%0d/%0d want=3/0", r_dreq, r_we); end
    total++; if (r_rfwe !== 1) begin bad++; $display("FAIL ld_rfwe got=%0d want=1", r_rfwe); end
    total++; if (retired !== 3'd4 || imem_addr !== 32'h10) begin bad++; $display("FAIL ld_retire got=%0d/%0h want=4/10", retired, imem_addr); end
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1; ex_branch_pc = 32'h40;
    run_instr(32'h0, 0, 0, 1'b0);
    ex_branch_taken = 1'b0;
    total++; if (r_cyc !== 3) begin bad++; $display("FAIL br_cycles got=%0d want=3", r_cyc); end
    total++; if (r_rfwe !== 0 || r_dreq !== 0) begin bad++; $display("FAIL br_side got=%0d/%0d want=0/0", r_rfwe, r_dreq); end
    total++; if (imem_addr !== 32'h40 || state !== 3'd1) begin bad++; $display("FAIL br_target got=%0h want=40", imem_addr); end
    total++; if (retired !== 3'd5) begin bad++; $display("FAIL br_retired got=%0d want=5", retired); end
  endtask

  task automatic test_store_pause();
    run_instr(32'h4, 0, 0, 1'b1);
    total++; if (r_cyc !== 4 || r_we !== 1 || r_rfwe !== 0) begin bad++; $display("FAIL st_run got=%0d/%0d/%0d want=4/1/0", r_cyc, r_we, r_rfwe); end
    total++; if (state !== 3'd0 || pc !== 32'h44) begin bad++; $display("FAIL st_idle got=%0d/%0h want=0/44", state, pc); end
    total++; if (retired !== 3'd6) begin bad++; $display("FAIL st_retired got=%0d want=6", retired); end
    @(negedge Clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL pause_hold got=%0d want=0", state); end
    run = 1'b1;
    @(negedge Clk);
    total++; if (state !== 3'd1 || imem_addr !== 32'h44) begin bad++; $display("FAIL resume got=%0d/%0h want=1/44", state, imem_addr); end
    // ld and st both set: store, no writeback
    run_instr(32'h7, 0, 0, 1'b0);
    total++; if (r_cyc !== 4 || r_we !== 1 || r_rfwe !== 0) begin bad++; $display("FAIL ldst got=%0d/%0d/%0d want=4/1/0", r_cyc, r_we, r_rfwe); end
    total++; if (retired !== 3'd7 || imem_addr !== 32'h48) begin bad++; $display("FAIL ldst_retire got=%0d/%0h want=7/48", retired, imem_addr); end
  endtask

  task automatic test_wrap_saturate();
    ex_branch_taken = 1'b1; ex_branch_pc = 32'hFFFF_FFFC;
    run_instr(32'h0, 0, 0, 1'b0);
    ex_branch_taken = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_br got=%0h want=fffffffc", imem_addr); end
    total++; if (retired !== 3'd7) begin bad++; $display("FAIL sat1 got=%0d want=7", retired); end
    run_instr(32'h1, 0, 0, 1'b0);
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%0h want=0", imem_addr); end
    total++; if (retired !== 3'd7) begin bad++; $display("FAIL sat2 got=%0d want=7", retired); end
  endtask

  task automatic test_timeout_halt();
    do_reset();
    run = 1'b1;
    @(negedge Clk);
    run_instr(32'h1, 100, 0, 1'b0);
    total++; if (r_cyc !== 16) begin bad++; $display("FAIL to_cycles got=%0d want=16", r_cyc); end
    total++; if (state !== 3'd7 || fault !== 1'b1 || imem_req !== 1'b0)
      begin bad++; $display("FAIL to_fault got=%0d/%b/%b want=7/1/0", state, fault, imem_req); end
    imem_ack = 1'b1;
    @(negedge Clk); @(negedge Clk);
    imem_ack = 1'b0;
    total++; if (state !== 3'd7 || fault !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0d want=7", state); end
    // ack on the 16th request cycle wins
    do_reset();
    run = 1'b1;
    @(negedge Clk);
    run_instr(32'h1, 15, 0, 1'b0);
    total++; if (r_cyc !== 19 || fault !== 1'b0 || state !== 3'd1)
      begin bad++; $display("FAIL to_edge got=%0d/%b/%0d want=19/0/1", r_cyc, fault, state); end
    total++; if (retired !== 3'd1 || imem_addr !== 32'h4) begin bad++; $display("FAIL to_edge_ret got=%0d/%0h want=1/4", retired, imem_addr); end
    // halt at pc 4
    run_instr(32'h8, 0, 0, 1'b0);
    total++; if (r_cyc !== 2 || state !== 3'd6 || halted !== 1'b1)
      begin bad++; $display("FAIL halt got=%0d/%0d/%b want=2/6/1", r_cyc, state, halted); end
    @(negedge Clk); @(negedge Clk);
    total++; if (state !== 3'd6 || retired !== 3'd1 || pc !== 32'h4)
      begin bad++; $display("FAIL halt_sticky got=%0d/%0d/%0h want=6/1/4", state, retired, pc); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run = 1'b1;
    @(negedge Clk);
    imem_ack = 1'b1; imem_rdata = 32'h3;
    @(negedge Clk);
    imem_ack = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    total++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0)
      begin bad++; $display("FAIL mem_enter got=%0d/%b/%b want=4/1/0", state, dmem_req, dmem_we); end
    Reset = 1'b1;
    @(negedge Clk);
    total++; if (dmem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0)
      begin bad++; $display("FAIL mid_reset got=%b/%0d/%0h want=0/0/0", dmem_req, state, pc); end
    Reset = 1'b0; run = 1'b0; dmem_ack = 1'b1;
    @(negedge Clk);
    dmem_ack = 1'b0;
    total++; if (state !== 3'd0 || dmem_req !== 1'b0 || retired !== 3'd0)
      begin bad++; $display("FAIL late_ack got=%0d/%b/%0d want=0/0/0", state, dmem_req, retired); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_store_pause();
    test_wrap_saturate();
    test_timeout_halt();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
